// File: rtl/ula_lo_seq.sv
// ula_lo_seq - multi-cycle sequencer and flag register for the logic-only ALU.
//
// Accepts one operation per start pulse. Logical ops (10000..11111) take a single
// ALU pass; LSL (01000) and ASR (01001) iterate the ALU's 1-bit shift shamt times.
// Holds the architectural result and C/S/Z flags and pulses done (plus illegal for
// unsupported codes) for one cycle when the operation completes.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   start           request, sampled only in IDLE
//   op, a, b, shamt operation code, operands, shift amount (latched on start)
//   busy            high while in SHIFT or EXEC
//   done, illegal   one-cycle completion / unsupported-op pulses
//   result          registered result
//   flag_c/s/z      registered carry, sign and zero flags
module ula_lo_seq #(
    parameter int unsigned BITS = 16,
    parameter int unsigned SHW  = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [4:0]      op,
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    input  logic [SHW-1:0]  shamt,
    output logic            busy,
    output logic            done,
    output logic            illegal,
    output logic [BITS-1:0] result,
    output logic            flag_c,
    output logic            flag_s,
    output logic            flag_z
);

    localparam logic [4:0] OpLsl   = 5'b01000;
    localparam logic [4:0] OpAsr   = 5'b01001;
    localparam logic [4:0] OpZero  = 5'b10000;
    localparam logic [4:0] OpPassB = 5'b10011;
    localparam logic [4:0] OpOne   = 5'b11111;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StExec,
        StFinish
    } state_e;

    state_e          state_q;
    logic [4:0]      op_q;
    logic [BITS-1:0] opr_q;
    logic [BITS-1:0] b_q;
    logic [SHW-1:0]  cnt_q;

    logic [BITS-1:0] alu_res;
    logic            alu_c;

    logic            start_shift;
    logic            start_logic;

    assign start_shift = (op == OpLsl) || (op == OpAsr);
    assign start_logic = op[4];

    // ALU: one pass over opr/b under the latched op.
    // Logical ops treat op[3:0] as a truth table: bit index {~b, ~a} per bit,
    // so 0000 = zero, 0001 = AND, 0011 = pass B, 0110 = XOR, 1111 = all ones.
    always_comb begin
        logic [1:0] sel;
        sel     = 2'b00;
        alu_res = '0;
        alu_c   = 1'b0;
        if (op_q == OpLsl) begin
            alu_res = {opr_q[BITS-2:0], 1'b0};
            alu_c   = opr_q[BITS-1];
        end else if (op_q == OpAsr) begin
            alu_res = {opr_q[BITS-1], opr_q[BITS-1:1]};
            alu_c   = opr_q[0];
        end else if (op_q[4]) begin
            for (int i = 0; i < BITS; i++) begin
                sel        = {~b_q[i], ~opr_q[i]};
                alu_res[i] = op_q[sel];
            end
        end
    end

    // Sequencer, working registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            op_q    <= '0;
            opr_q   <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            result  <= '0;
            flag_c  <= 1'b0;
            flag_s  <= 1'b0;
            flag_z  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            illegal <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done    <= 1'b0;
                    illegal <= 1'b0;
                    if (start) begin
                        op_q  <= op;
                        opr_q <= a;
                        b_q   <= b;
                        cnt_q <= shamt;
                        if (start_shift && (shamt != '0)) begin
                            busy    <= 1'b1;
                            state_q <= StShift;
                        end else if (start_shift) begin
                            // Zero-length shift: result is A, nothing shifted out.
                            result  <= a;
                            flag_c  <= 1'b0;
                            flag_s  <= a[BITS-1];
                            flag_z  <= (a == '0);
                            done    <= 1'b1;
                            state_q <= StFinish;
                        end else if (start_logic) begin
                            busy    <= 1'b1;
                            state_q <= StExec;
                        end else begin
                            // Unsupported code: result and flags untouched.
                            done    <= 1'b1;
                            illegal <= 1'b1;
                            state_q <= StFinish;
                        end
                    end
                end

                StShift: begin
                    opr_q  <= alu_res;
                    flag_c <= alu_c;
                    cnt_q  <= cnt_q - SHW'(1);
                    if (cnt_q == SHW'(1)) begin
                        result  <= alu_res;
                        flag_s  <= alu_res[BITS-1];
                        flag_z  <= (alu_res == '0);
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= StFinish;
                    end
                end

                StExec: begin
                    result <= alu_res;
                    if (op_q == OpZero) begin
                        flag_z <= 1'b1;
                    end else if ((op_q != OpPassB) && (op_q != OpOne)) begin
                        flag_s <= alu_res[BITS-1];
                        flag_z <= (alu_res == '0);
                    end
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    state_q <= StFinish;
                end

                StFinish: begin
                    done    <= 1'b0;
                    illegal <= 1'b0;
                    state_q <= StIdle;
                end

                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    illegal <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ula_lo_seq.sv
// Directed self-checking bench for ula_lo_seq (BITS=16, SHW=5).
module tb_ula_lo_seq;

    localparam int unsigned BITS = 16;
    localparam int unsigned SHW  = 5;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [4:0]      op;
    logic [BITS-1:0] a;
    logic [BITS-1:0] b;
    logic [SHW-1:0]  shamt;
    logic            busy;
    logic            done;
    logic            illegal;
    logic [BITS-1:0] result;
    logic            flag_c;
    logic            flag_s;
    logic            flag_z;

    int n_checks;
    int n_fail;

    ula_lo_seq #(
        .BITS (BITS),
        .SHW  (SHW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .shamt   (shamt),
        .busy    (busy),
        .done    (done),
        .illegal (illegal),
        .result  (result),
        .flag_c  (flag_c),
        .flag_s  (flag_s),
        .flag_z  (flag_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [15:0] r, input logic c,
                             input logic s, input logic z);
        chk({tag, " result"}, 32'(result), 32'(r));
        chk({tag, " flag_c"}, 32'(flag_c), 32'(c));
        chk({tag, " flag_s"}, 32'(flag_s), 32'(s));
        chk({tag, " flag_z"}, 32'(flag_z), 32'(z));
    endtask

    // Issue one operation from IDLE and wait (bounded) for done; checks latency,
    // busy while working, the illegal pulse, and that done lasts one cycle.
    task automatic run_op(input string tag, input logic [4:0] o, input logic [15:0] ia,
                          input logic [15:0] ib, input logic [4:0] sa, input int exp_lat,
                          input logic exp_ill);
        int cyc;
        op    = o;
        a     = ia;
        b     = ib;
        shamt = sa;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc   = 1;
        while (!done && cyc < 60) begin
            chk({tag, " busy"}, 32'(busy), 32'd1);
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({tag, " latency"}, 32'(cyc), 32'(exp_lat));
        chk({tag, " busy@done"}, 32'(busy), 32'd0);
        chk({tag, " illegal"}, 32'(illegal), 32'(exp_ill));
    endtask

    task automatic step_idle(input string tag);
        @(posedge clk);
        #1;
        chk({tag, " done pulse width"}, 32'(done), 32'd0);
    endtask

    initial begin
        int ndone;
        int done_cyc;
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        op       = '0;
        a        = '0;
        b        = '0;
        shamt    = '0;
        #12;
        chk_state("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset illegal", 32'(illegal), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle done", 32'(done), 32'd0);
        chk("idle busy", 32'(busy), 32'd0);

        run_op("and", 5'b10001, 16'hF0F0, 16'hFF00, 5'd0, 2, 1'b0);
        chk_state("and", 16'hF000, 1'b0, 1'b1, 1'b0);
        step_idle("and");

        run_op("lsl4", 5'b01000, 16'h1234, 16'h0000, 5'd4, 5, 1'b0);
        chk_state("lsl4", 16'h2340, 1'b1, 1'b0, 1'b0);
        step_idle("lsl4");

        run_op("lsl16", 5'b01000, 16'h0001, 16'h0000, 5'd16, 17, 1'b0);
        chk_state("lsl16", 16'h0000, 1'b1, 1'b0, 1'b1);
        step_idle("lsl16");

        run_op("lsl17", 5'b01000, 16'hFFFF, 16'h0000, 5'd17, 18, 1'b0);
        chk_state("lsl17", 16'h0000, 1'b0, 1'b0, 1'b1);
        step_idle("lsl17");

        run_op("xor", 5'b10110, 16'hF0F0, 16'hFF00, 5'd3, 2, 1'b0);
        chk_state("xor", 16'h0FF0, 1'b0, 1'b0, 1'b0);
        step_idle("xor");

        run_op("asr3", 5'b01001, 16'h8005, 16'h0000, 5'd3, 4, 1'b0);
        chk_state("asr3", 16'hF000, 1'b1, 1'b1, 1'b0);
        step_idle("asr3");

        run_op("asr20", 5'b01001, 16'h8000, 16'h0000, 5'd20, 21, 1'b0);
        chk_state("asr20", 16'hFFFF, 1'b1, 1'b1, 1'b0);
        step_idle("asr20");

        run_op("asr0", 5'b01001, 16'h8005, 16'h0000, 5'd0, 1, 1'b0);
        chk_state("asr0", 16'h8005, 1'b0, 1'b1, 1'b0);
        step_idle("asr0");

        run_op("passb", 5'b10011, 16'hFFFF, 16'h0000, 5'd0, 2, 1'b0);
        chk_state("passb", 16'h0000, 1'b0, 1'b1, 1'b0);
        step_idle("passb");

        run_op("zero", 5'b10000, 16'h1234, 16'h5678, 5'd0, 2, 1'b0);
        chk_state("zero", 16'h0000, 1'b0, 1'b1, 1'b1);
        step_idle("zero");

        run_op("ill00101", 5'b00101, 16'h1234, 16'h5678, 5'd2, 1, 1'b1);
        chk_state("ill00101", 16'h0000, 1'b0, 1'b1, 1'b1);
        step_idle("ill00101");
        chk("ill00101 illegal width", 32'(illegal), 32'd0);

        run_op("ill01111", 5'b01111, 16'hFFFF, 16'hFFFF, 5'd0, 1, 1'b1);
        chk_state("ill01111", 16'h0000, 1'b0, 1'b1, 1'b1);
        step_idle("ill01111");

        run_op("one", 5'b11111, 16'h0000, 16'h0000, 5'd0, 2, 1'b0);
        chk_state("one", 16'hFFFF, 1'b0, 1'b1, 1'b1);
        step_idle("one");

        // start (with new operands) during a shamt=8 shift must be ignored.
        op    = 5'b01000;
        a     = 16'h0003;
        b     = 16'h0000;
        shamt = 5'd8;
        start = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        ndone    = 0;
        done_cyc = 0;
        for (int k = 1; k <= 14; k++) begin
            if (done) begin
                ndone++;
                done_cyc = k;
            end
            if (k == 2) begin
                op    = 5'b10000;
                a     = 16'h0000;
                shamt = 5'd1;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        chk("ignored-start done count", 32'(ndone), 32'd1);
        chk("ignored-start done cycle", 32'(done_cyc), 32'd9);
        chk_state("ignored-start", 16'h0300, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a shamt=8 LSL aborts with no done pulse.
        op    = 5'b01000;
        a     = 16'hFFFF;
        shamt = 5'd8;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        #2;
        rst_n = 1'b0;
        #1;
        chk_state("midreset", 16'h0000, 1'b0, 1'b0, 1'b0);
        chk("midreset busy", 32'(busy), 32'd0);
        chk("midreset done", 32'(done), 32'd0);
        chk("midreset illegal", 32'(illegal), 32'd0);
        ndone = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("midreset no done", 32'(ndone), 32'd0);
        chk("midreset idle busy", 32'(busy), 32'd0);

        run_op("and2", 5'b10001, 16'h00FF, 16'h0F0F, 5'd0, 2, 1'b0);
        chk_state("and2", 16'h000F, 1'b0, 1'b0, 1'b0);
        step_idle("and2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ula_lo_seq.md
# ula_lo_seq

Multi-cycle sequencer and flag register for the logic-only ALU. Accepts one operation per start pulse, executes logical operations in a single ALU pass and iterates the ALU's 1-bit shift operations to implement shifts by a run-time amount. Holds the architectural result and C/S/Z flags under the ALU's flag-update rules, and reports completion with a one-cycle done pulse. Sits between instruction decode and the register file write-back.

## Interface
- BITS, 16, data width; passed through to the ALU instance
- SHW, 5, width of the shift-amount port
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- op  in  5  ALU operation code
- a  in  BITS  operand A (shift source)
- b  in  BITS  operand B
- shamt  in  SHW  shift amount; shift ops only
- busy  out  1  high in SHIFT and EXEC
- done  out  1  one-cycle completion pulse
- illegal  out  1  one-cycle pulse with done for an unsupported op
- result  out  BITS  registered result
- flag_c, flag_s, flag_z  out  1 each  registered carry, sign and zero flags

## Operation
- FSM states: IDLE, SHIFT, EXEC, FINISH. The block owns one ALU instance. ALU A input = working register opr; ALU B input = latched b; ALU OP input = latched op.
- IDLE with start=1: latch op, a into opr, b, shamt into cnt. Next state:
  - SHIFT for op 01000 (LSL) or 01001 (ASR) with shamt≠0.
  - FINISH for a shift with shamt=0.
  - EXEC for a valid logical op.
  - FINISH for any other code.
- Valid logical ops are 10000 through 11111, all 16 codes.
- Illegal codes are 00000–00111 and 01010–01111.
- SHIFT, each cycle:
  - opr ← ALU result; flag_c ← ALU carry; cnt ← cnt−1.
  - On the cycle where cnt=1, also load result, flag_s ← result MSB, flag_z ← (result==0), then go to FINISH.
  - LSL step: shift left, 0 fill; C = old MSB.
  - ASR step: shift right, sign fill; C = old bit 0.
- Shifts with shamt ≥ BITS are legal:
  - LSL reaches 0; C = 0 once shamt > BITS.
  - ASR saturates to all sign bits; C = sign.
- Shift with shamt=0:
  - result ← a; flag_c ← 0.
  - flag_s and flag_z are set from a.
- EXEC: result ← ALU result. Flag rules:
  - 10011 (pass B) and 11111 (constant 1): flag_s and flag_z held.
  - 10000 (zero): flag_z ← 1, flag_s held.
  - All other logical ops: flag_s ← MSB, flag_z ← (result==0).
  - flag_c is always held.
  - Go to FINISH.
- FINISH:
  - done=1 for exactly this cycle. illegal=1 in the same cycle when the op was illegal.
  - For an illegal op, result and all flags are held.
  - Next state is IDLE unconditionally.
- start outside IDLE (SHIFT, EXEC, FINISH) is ignored, not queued.
- Changes on op, a, b or shamt after the start cycle have no effect until the next accepted start.

## Timing
- Cycle 0 is the edge that samples start in IDLE. Latencies:
  - Logical op: EXEC in cycle 1, done in cycle 2.
  - Shift by n>0: SHIFT in cycles 1..n, done in cycle n+1.
  - Shift by 0 or illegal op: done in cycle 1.
- result and the flags change on the edge that enters FINISH, so they are valid while done=1. They hold until the next operation updates them.
- busy goes high the cycle after start is accepted and falls on entry to FINISH.
- Next start is accepted in the cycle after done, which is the earliest IDLE cycle.
- Reset, asynchronous, active low:
  - state=IDLE.
  - result, opr, cnt = 0.
  - flag_c, flag_s, flag_z, busy, done, illegal = 0.
- Reset asserted mid-SHIFT or mid-EXEC aborts the operation immediately. No done pulse is produced.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
All values use BITS=16.
- Reset, then idle: all outputs 0. start=1, op=10001, a=0xF0F0, b=0xFF00 → done at cycle 2, result=0xF000, flag_s=1, flag_z=0, flag_c=0.
- LSL: op=01000, a=0x1234, shamt=4 → busy in cycles 1–4, done at cycle 5, result=0x2340, flag_c=1, flag_s=0, flag_z=0. With shamt=16, a=0x0001 → result=0x0000, flag_c=1, flag_z=1.
- ASR: op=01001, a=0x8005, shamt=3 → done at cycle 4, result=0xF000, flag_c=1, flag_s=1. With shamt=0 → done at cycle 1, result=0x8005, flag_c=0, flag_s=1.
- Flag hold: after the ASR case (flag_s=1, flag_z=0):
  - op=10011, b=0x0000 → result=0x0000; flags unchanged (flag_s=1, flag_z=0).
  - Then op=10000 → flag_z=1, flag_s still 1, flag_c unchanged.
- Illegal op 00101 → done and illegal pulse together at cycle 1; result and flags unchanged. start pulsed during a shamt=8 shift is ignored, and exactly one done follows.
- rst_n low at cycle 3 of a shamt=8 LSL → all outputs 0 immediately, no done pulse. A new AND op started after reset release completes normally.
